spi_master_param: RTL and testbench

- Parametrised full-duplex SPI master; successor to the fixed 8-bit, clock-passthrough SPI controller.
- Adds configurable word width, internal SPI clock divider, all four CPOL/CPHA modes, MSB/LSB-first order and multiple chip selects.
- Sits between the system-side strobe/ack interface and the off-chip SPI pins.
- One word is transmitted and received per W_STB.

---
 rtl/spi_master_param.sv | 213 +++++++++++++++++++++
 tb/tb_spi_master_param.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_param.sv
// spi_master_param: parametrised full-duplex SPI master.
// Accepts one word per W_STB on the system side and runs one SPI frame with
// configurable width, clock divider, CPOL/CPHA mode, bit order and chip
// select count. All logic runs on the rising edge of SCLK with a
// synchronous active-high reset RST.
// Optional build macro SPI_MASTER_LOOPBACK_EN adds a LOOPBACK input that
// makes the receive path sample the internal MOSI instead of MISO.
module spi_master_param #(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 4,
    parameter int CPOL      = 0,
    parameter int CPHA      = 0,
    parameter int LSB_FIRST = 0,
    parameter int CS_CNT    = 1
) (
    input  logic                                           SCLK,
    input  logic                                           RST,
    input  logic                                           W_STB,
    input  logic [DATA_W-1:0]                              W_DATA,
    input  logic [((CS_CNT > 1) ? $clog2(CS_CNT) : 1)-1:0] W_SEL,
    output logic                                           W_ACK,
    output logic                                           R_STB,
    output logic [DATA_W-1:0]                              R_DATA,
    output logic                                           BUSY,
    output logic                                           SPI_CLK,
    output logic                                           MOSI,
    input  logic                                           MISO,
    output logic [CS_CNT-1:0]                              CS_N
`ifdef SPI_MASTER_LOOPBACK_EN
    ,
    input  logic                                           LOOPBACK
`endif
);

    localparam int SEL_W  = (CS_CNT > 1) ? $clog2(CS_CNT) : 1;
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W + 1);

    localparam logic SPI_IDLE = (CPOL != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEAD,
        ST_SHIFT,
        ST_TRAIL
    } state_t;

    state_t              state_q;
    logic [DIV_W-1:0]    divCnt_q;
    logic [EDGE_W-1:0]   edgeCnt_q;
    logic [DATA_W-1:0]   txShift_q;
    logic [DATA_W-1:0]   rxShift_q;
    logic [DATA_W-1:0]   rData_q;
    logic                wAck_q;
    logic                rStb_q;
    logic                busy_q;
    logic                spiClk_q;
    logic                mosi_q;
    logic [CS_CNT-1:0]   csN_q;

    logic                sampleBit_d;
    logic [DATA_W-1:0]   txShift_d;
    logic [DATA_W-1:0]   rxShift_d;
    logic                wFirst_d;
    logic                txFirst_d;
    logic                txNextFirst_d;
    logic [CS_CNT-1:0]   csSel_d;
    logic                divLast_d;
    logic                leadingEdge_d;
    logic                sampleEdge_d;
    logic                finalEdge_d;
    logic                lastTrailing_d;

    // Receive source: MISO straight from the pin, or MOSI when looped back.
    always_comb begin
        sampleBit_d = MISO;
`ifdef SPI_MASTER_LOOPBACK_EN
        if (LOOPBACK) begin
            sampleBit_d = mosi_q;
        end
`endif
    end

    // Shift-register next values and first-bit selection for the chosen bit order.
    always_comb begin
        txShift_d     = txShift_q;
        rxShift_d     = rxShift_q;
        wFirst_d      = 1'b1;
        txFirst_d     = 1'b1;
        txNextFirst_d = 1'b1;
        if (LSB_FIRST != 0) begin
            txShift_d     = {1'b0, txShift_q[DATA_W-1:1]};
            rxShift_d     = {sampleBit_d, rxShift_q[DATA_W-1:1]};
            wFirst_d      = W_DATA[0];
            txFirst_d     = txShift_q[0];
            txNextFirst_d = txShift_q[1];
        end else begin
            txShift_d     = {txShift_q[DATA_W-2:0], 1'b0};
            rxShift_d     = {rxShift_q[DATA_W-2:0], sampleBit_d};
            wFirst_d      = W_DATA[DATA_W-1];
            txFirst_d     = txShift_q[DATA_W-1];
            txNextFirst_d = txShift_q[DATA_W-2];
        end
    end

    // Chip-select decode; an out-of-range index leaves every line high.
    always_comb begin
        csSel_d = '1;
        for (int i = 0; i < CS_CNT; i++) begin
            if (W_SEL == SEL_W'(i)) begin
                csSel_d[i] = 1'b0;
            end
        end
    end

    // Edge bookkeeping: edgeCnt_q holds the number of toggles already made,
    // so the next toggle is a leading edge whenever that count is even.
    always_comb begin
        divLast_d      = (divCnt_q == DIV_W'(CLK_DIV - 1));
        leadingEdge_d  = ~edgeCnt_q[0];
        sampleEdge_d   = (CPHA == 0) ? leadingEdge_d : ~leadingEdge_d;
        finalEdge_d    = (edgeCnt_q == EDGE_W'(2 * DATA_W));
        lastTrailing_d = (edgeCnt_q == EDGE_W'(2 * DATA_W - 1));
    end

    // Frame sequencer: IDLE -> LEAD -> SHIFT -> TRAIL -> IDLE, all outputs registered.
    always_ff @(posedge SCLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            divCnt_q  <= '0;
            edgeCnt_q <= '0;
            txShift_q <= '0;
            rxShift_q <= '0;
            rData_q   <= '0;
            wAck_q    <= 1'b0;
            rStb_q    <= 1'b0;
            busy_q    <= 1'b0;
            spiClk_q  <= SPI_IDLE;
            mosi_q    <= 1'b1;
            csN_q     <= '1;
        end else begin
            wAck_q <= 1'b0;
            rStb_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (W_STB) begin
                        state_q   <= ST_LEAD;
                        divCnt_q  <= '0;
                        edgeCnt_q <= '0;
                        txShift_q <= W_DATA;
                        rxShift_q <= '0;
                        wAck_q    <= 1'b1;
                        busy_q    <= 1'b1;
                        csN_q     <= csSel_d;
                        spiClk_q  <= SPI_IDLE;
                        mosi_q    <= (CPHA == 0) ? wFirst_d : 1'b1;
                    end
                end

                ST_LEAD, ST_SHIFT: begin
                    if (divLast_d) begin
                        divCnt_q <= '0;
                        if ((state_q == ST_SHIFT) && finalEdge_d) begin
                            state_q <= ST_TRAIL;
                            mosi_q  <= 1'b1;
                        end else begin
                            state_q   <= ST_SHIFT;
                            spiClk_q  <= ~spiClk_q;
                            edgeCnt_q <= edgeCnt_q + EDGE_W'(1);
                            if (sampleEdge_d) begin
                                rxShift_q <= rxShift_d;
                            end else if (CPHA != 0) begin
                                mosi_q    <= txFirst_d;
                                txShift_q <= txShift_d;
                            end else if (!lastTrailing_d) begin
                                mosi_q    <= txNextFirst_d;
                                txShift_q <= txShift_d;
                            end
                        end
                    end else begin
                        divCnt_q <= divCnt_q + DIV_W'(1);
                    end
                end

                ST_TRAIL: begin
                    if (divLast_d) begin
                        state_q  <= ST_IDLE;
                        divCnt_q <= '0;
                        csN_q    <= '1;
                        busy_q   <= 1'b0;
                        rStb_q   <= 1'b1;
                        rData_q  <= rxShift_q;
                    end else begin
                        divCnt_q <= divCnt_q + DIV_W'(1);
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign W_ACK   = wAck_q;
    assign R_STB   = rStb_q;
    assign R_DATA  = rData_q;
    assign BUSY    = busy_q;
    assign SPI_CLK = spiClk_q;
    assign MOSI    = mosi_q;
    assign CS_N    = csN_q;

endmodule

// File: tb/tb_spi_master_param.sv
// tb_spi_master_param: bench for spi_master_param.
// Five masters (modes 0..3 MSB-first, plus mode 0 LSB-first), each with a
// behavioural SPI slave, are driven from a vector table and a few
// hand-written sequences (busy/back-to-back, reset mid-frame).
module tb_spi_master_param;

   localparam int N = 5;

   typedef struct {
      int         idx;
      logic [7:0] wData;
      logic [1:0] wSel;
      logic       lb;
      logic [7:0] expRData;
      logic [7:0] expSlave;
      logic [3:0] expCsN;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       wStb [N];
   logic [7:0] wData [N];
   logic [1:0] wSel [N];
   logic       lbOn [N];
   logic       wAck [N];
   logic       rStb [N];
   logic       busy [N];
   logic       spiClk [N];
   logic       mosi [N];
   logic [7:0] rData [N];
   logic [3:0] csN [N];

   logic       slvMiso [N];
   logic [7:0] slvRx [N];
   logic       spiPrev [N];
   logic       csPrev [N];
   int         sIdx [N];

   int nTests = 0;
   int nFail  = 0;

   vec_t vecs [8];
   int   nVec;

   always #5 clk = ~clk;

   // One master per configuration; index 4 is the LSB-first instance.
   for (genvar m = 0; m < N; m++) begin : gDut
      spi_master_param #(
         .DATA_W   (8),
         .CLK_DIV  (2),
         .CPOL     ((m == 4) ? 0 : ((m >> 1) & 1)),
         .CPHA     ((m == 4) ? 0 : (m & 1)),
         .LSB_FIRST((m == 4) ? 1 : 0),
         .CS_CNT   (4)
      ) uDut (
         .SCLK    (clk),
         .RST     (rst),
         .W_STB   (wStb[m]),
         .W_DATA  (wData[m]),
         .W_SEL   (wSel[m]),
         .W_ACK   (wAck[m]),
         .R_STB   (rStb[m]),
         .R_DATA  (rData[m]),
         .BUSY    (busy[m]),
         .SPI_CLK (spiClk[m]),
         .MOSI    (mosi[m]),
         .MISO    (lbOn[m] ? 1'b0 : slvMiso[m]),
`ifdef SPI_MASTER_LOOPBACK_EN
         .LOOPBACK(lbOn[m]),
`endif
         .CS_N    (csN[m])
      );
   end

   function automatic logic cpolOf(input int k);
      return (k < 4) && (((k >> 1) & 1) == 1);
   endfunction

   function automatic logic cphaOf(input int k);
      return (k < 4) && ((k & 1) == 1);
   endfunction

   function automatic logic lsbOf(input int k);
      return k == 4;
   endfunction

   function automatic logic slaveBit(input int k, input int n);
      logic [7:0] w;
      w = (k == 4) ? 8'h80 : 8'h3C;
      return lsbOf(k) ? w[n] : w[7 - n];
   endfunction

   // Behavioural slaves: watch SPI_CLK between system edges, capture MOSI on
   // the sample edge and move MISO on the shift edge of each mode.
   always @(negedge clk) begin
      for (int k = 0; k < N; k++) begin
         if (csN[k] == 4'hF) begin
            slvMiso[k] = 1'b1;
            csPrev[k]  = 1'b0;
         end else begin
            if (!csPrev[k]) begin
               sIdx[k]  = 0;
               slvRx[k] = 8'h00;
               if (!cphaOf(k)) begin
                  slvMiso[k] = slaveBit(k, 0);
                  sIdx[k]    = 1;
               end
            end else if (spiClk[k] != spiPrev[k]) begin
               if ((spiClk[k] != cpolOf(k)) != cphaOf(k)) begin
                  if (lsbOf(k)) slvRx[k] = {mosi[k], slvRx[k][7:1]};
                  else          slvRx[k] = {slvRx[k][6:0], mosi[k]};
               end else begin
                  if (sIdx[k] < 8) slvMiso[k] = slaveBit(k, sIdx[k]);
                  sIdx[k] = sIdx[k] + 1;
               end
            end
            csPrev[k] = 1'b1;
         end
         spiPrev[k] = spiClk[k];
      end
   end

   // Single comparison point: counts every check and reports failures.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Present a request for one cycle starting at the current negedge.
   task automatic applyStimulus(input int idx, input logic [7:0] d, input logic [1:0] s, input logic lb);
      wStb[idx]  = 1'b1;
      wData[idx] = d;
      wSel[idx]  = s;
      lbOn[idx]  = lb;
      @(negedge clk);
      wStb[idx]  = 1'b0;
   endtask

   // Count negedges from W_ACK until R_STB (bounded), watching CS_N and W_ACK;
   // optionally inject a W_STB while busy at cycle injectAt.
   task automatic waitRStb(input int idx, input logic [3:0] expCs, input int injectAt,
                           output int t, output int csBad, output int ackExtra);
      t = 0; csBad = 0; ackExtra = 0;
      while (rStb[idx] !== 1'b1 && t < 200) begin
         if (t == injectAt) begin
            wStb[idx]  = 1'b1;
            wData[idx] = 8'hFF;
         end
         @(negedge clk);
         wStb[idx] = 1'b0;
         t++;
         if (rStb[idx] !== 1'b1 && csN[idx] !== expCs) csBad++;
         if (wAck[idx] === 1'b1) ackExtra++;
      end
   endtask

   task automatic runVector(input vec_t v);
      int t, csBad, ackExtra;
      @(negedge clk);
      checkOutput("idleClk", spiClk[v.idx], cpolOf(v.idx));
      checkOutput("idleBusy", busy[v.idx], 0);
      applyStimulus(v.idx, v.wData, v.wSel, v.lb);
      checkOutput("ack", wAck[v.idx], 1);
      checkOutput("busyAck", busy[v.idx], 1);
      checkOutput("csAck", csN[v.idx], v.expCsN);
      waitRStb(v.idx, v.expCsN, -1, t, csBad, ackExtra);
      checkOutput("frameLen", t, 36);
      checkOutput("csHeld", csBad, 0);
      checkOutput("ackOnce", ackExtra, 0);
      checkOutput("rData", rData[v.idx], v.expRData);
      checkOutput("busyDone", busy[v.idx], 0);
      checkOutput("csDone", csN[v.idx], 4'hF);
      checkOutput("slaveRx", slvRx[v.idx], v.expSlave);
      @(negedge clk);
      checkOutput("rStbPulse", rStb[v.idx], 0);
      lbOn[v.idx] = 1'b0;
   endtask

   initial begin
      int t, csBad, ackExtra, seen;
      rst = 1'b1;
      for (int k = 0; k < N; k++) begin
         wStb[k] = 1'b0; wData[k] = 8'h00; wSel[k] = 2'd0; lbOn[k] = 1'b0;
      end
      repeat (3) @(negedge clk);

      // Reset state of every instance.
      for (int k = 0; k < N; k++) begin
         checkOutput("rstAck", wAck[k], 0);
         checkOutput("rstRStb", rStb[k], 0);
         checkOutput("rstRData", rData[k], 0);
         checkOutput("rstBusy", busy[k], 0);
         checkOutput("rstClk", spiClk[k], cpolOf(k));
         checkOutput("rstMosi", mosi[k], 1);
         checkOutput("rstCs", csN[k], 4'hF);
      end
      rst = 1'b0;

      nVec = 0;
      vecs[nVec++] = '{0, 8'hA5, 2'd0, 1'b0, 8'h3C, 8'hA5, 4'b1110};
      vecs[nVec++] = '{1, 8'hA5, 2'd0, 1'b0, 8'h3C, 8'hA5, 4'b1110};
      vecs[nVec++] = '{2, 8'hA5, 2'd0, 1'b0, 8'h3C, 8'hA5, 4'b1110};
      vecs[nVec++] = '{3, 8'hA5, 2'd0, 1'b0, 8'h3C, 8'hA5, 4'b1110};
      vecs[nVec++] = '{4, 8'h01, 2'd0, 1'b0, 8'h80, 8'h01, 4'b1110};
      vecs[nVec++] = '{0, 8'hC3, 2'd3, 1'b0, 8'h3C, 8'hC3, 4'b0111};
      vecs[nVec++] = '{3, 8'h96, 2'd1, 1'b0, 8'h3C, 8'h96, 4'b1101};
`ifdef SPI_MASTER_LOOPBACK_EN
      vecs[nVec++] = '{0, 8'h5A, 2'd1, 1'b1, 8'h5A, 8'h5A, 4'b1101};
`endif
      for (int i = 0; i < nVec; i++) begin
         runVector(vecs[i]);
      end

      // Busy request ignored, then back-to-back request in the R_STB cycle.
      @(negedge clk);
      applyStimulus(0, 8'hA5, 2'd2, 1'b0);
      checkOutput("selAck", wAck[0], 1);
      checkOutput("selCs", csN[0], 4'b1011);
      waitRStb(0, 4'b1011, 10, t, csBad, ackExtra);
      checkOutput("busyLen", t, 36);
      checkOutput("busyCsHeld", csBad, 0);
      checkOutput("busyNoAck", ackExtra, 0);
      checkOutput("busyLatched", slvRx[0], 8'hA5);
      checkOutput("b2bCsHigh", csN[0], 4'hF);
      applyStimulus(0, 8'h3C, 2'd2, 1'b0);
      checkOutput("b2bAck", wAck[0], 1);
      checkOutput("b2bCs", csN[0], 4'b1011);
      waitRStb(0, 4'b1011, -1, t, csBad, ackExtra);
      checkOutput("b2bLen", t, 36);
      checkOutput("b2bRData", rData[0], 8'h3C);
      checkOutput("b2bSlave", slvRx[0], 8'h3C);

      // Reset in the middle of SHIFT aborts the frame.
      @(negedge clk);
      applyStimulus(1, 8'hA5, 2'd0, 1'b0);
      repeat (12) @(negedge clk);
      checkOutput("midBusy", busy[1], 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("abortCs", csN[1], 4'hF);
      checkOutput("abortClk", spiClk[1], 0);
      checkOutput("abortMosi", mosi[1], 1);
      checkOutput("abortBusy", busy[1], 0);
      seen = 0;
      repeat (60) begin
         @(negedge clk);
         if (rStb[1] === 1'b1) seen++;
      end
      checkOutput("abortNoRStb", seen, 0);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

   // Absolute time limit so the bench always ends.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: got no end, expected completion");
      $fatal(1, "[TB] time limit reached");
   end

endmodule
